// File: rtl/weight_rom_stream_ctrl_pkg.sv
// weight_stream_pkg
//   Shared types and helpers for the weight ROM streamer.
//   wstream_state_t : sequencer states (IDLE / RUN / DRAIN)
//   fifo_cnt_width  : bits needed for an occupancy value 0..depth inclusive
package weight_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } wstream_state_t;

  function automatic int fifo_cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/weight_rom_stream_ctrl_if.sv
// weight_rom_stream_ctrl_if
//   Valid/ready weight-word stream from the ROM sequencer to the datapath.
//   data_out       : weight word
//   data_out_last  : word came from the final ROM address (end of pass)
//   data_out_valid : word valid
//   data_out_ready : consumer ready; transfer on valid && ready
//   master = producer (sequencer), slave = consumer.
interface weight_rom_stream_ctrl_if #(
  parameter int DATA_WIDTH = 128
);
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_last;
  logic                  data_out_valid;
  logic                  data_out_ready;

  modport master (
    output data_out, data_out_last, data_out_valid,
    input  data_out_ready
  );

  modport slave (
    input  data_out, data_out_last, data_out_valid,
    output data_out_ready
  );
endinterface

// File: rtl/weight_rom_stream_ctrl_fifo.sv
// weight_stream_fifo
//   Synchronous first-word-fall-through FIFO. dout shows the head entry
//   whenever the FIFO is non-empty and reads as zero when empty.
//   Push and pop may happen in the same cycle, including when full.
// Ports
//   clk, rst : clock, synchronous active-high reset (clears pointers/count)
//   push/din : write strobe and data
//   pop      : consume head entry (ignored when empty)
//   dout     : head entry
//   empty, full, count : occupancy status
module weight_stream_fifo
  import weight_stream_pkg::*;
#(
  parameter int WIDTH = 129,
  parameter int DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  logic [WIDTH-1:0]                   din,
  input  logic                               pop,
  output logic [WIDTH-1:0]                   dout,
  output logic                               empty,
  output logic                               full,
  output logic [fifo_cnt_width(DEPTH)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = fifo_cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the head slot that this push overwrites.
  assign do_push = push && (!full || pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/weight_rom_stream_ctrl.sv
// weight_rom_stream_ctrl
//   Sequences one weight ROM (ROM_LATENCY-cycle read, ce-gated) through
//   addresses 0..DEPTH-1 for repeat_count passes and streams the words out
//   via a credit-checked FWFT FIFO, so backpressure never drops or repeats
//   a word.
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   start          : pulse, accepted only in IDLE
//   repeat_count   : number of passes, latched on accepted start
//   busy           : high in RUN/DRAIN
//   done           : 1-cycle pulse after the final transfer (or after a
//                    zero-pass start)
//   rom_addr/rom_ce: ROM address0 / ce0
//   rom_q          : ROM q0
//   strm           : output word stream (master side)
module weight_rom_stream_ctrl
  import weight_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = 128,
  parameter int DEPTH        = 576,
  parameter int AWIDTH       = $clog2(DEPTH) + 1,
  parameter int ROM_LATENCY  = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [REPEAT_WIDTH-1:0] repeat_count,
  output logic                    busy,
  output logic                    done,
  output logic [AWIDTH-1:0]       rom_addr,
  output logic                    rom_ce,
  input  logic [DATA_WIDTH-1:0]   rom_q,
  weight_rom_stream_ctrl_if.master strm
);
  localparam int STAGES = ROM_LATENCY - 1;
  localparam int CW     = fifo_cnt_width(FIFO_DEPTH);

  generate
    if (ROM_LATENCY < 1 || FIFO_DEPTH < ROM_LATENCY + 2) begin : g_param_chk
      $error("weight_rom_stream_ctrl: need ROM_LATENCY>=1 and FIFO_DEPTH>=ROM_LATENCY+2");
    end
  endgenerate

  wstream_state_t state, state_d;
  logic           done_d;

  logic [AWIDTH-1:0]       addr;
  logic [REPEAT_WIDTH-1:0] pass, rep_q;
  logic [STAGES:0]         vld_pipe;   // read in flight, one bit per ROM stage
  logic [STAGES:0]         last_pipe;  // matching end-of-pass tag

  logic                  accept, issue, credit_ok, addr_last, pass_last;
  logic                  push, pop;
  logic                  fifo_empty, fifo_full;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH:0]   fifo_dout;
  int                    inflight;

  assign addr_last = (addr == AWIDTH'(DEPTH - 1));
  assign pass_last = (pass == rep_q - REPEAT_WIDTH'(1));

  // Every word already in the FIFO or still inside the ROM pipe holds a
  // slot; a pop this cycle deliberately earns nothing until it lands.
  always_comb begin
    inflight = int'(fifo_count);
    for (int i = 0; i <= STAGES; i++) inflight += int'(vld_pipe[i]);
  end
  assign credit_ok = (inflight < FIFO_DEPTH);

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    accept  = 1'b0;
    issue   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (repeat_count != '0) begin
            accept  = 1'b1;
            state_d = RUN;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        issue = credit_ok;
        if (issue && addr_last && pass_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (vld_pipe == '0 && fifo_empty) state_d = IDLE;
        // Final word leaves this cycle: flag done for the next one.
        if (vld_pipe == '0 && fifo_count == CW'(1) && pop) done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      done  <= done_d;
    end
  end

  // ---------------- address / pass / read pipe ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      pass      <= '0;
      rep_q     <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe  <= (vld_pipe << 1)  | (STAGES + 1)'(issue);
      last_pipe <= (last_pipe << 1) | (STAGES + 1)'(issue && addr_last);
      if (accept) begin
        addr  <= '0;
        pass  <= '0;
        rep_q <= repeat_count;
      end else if (issue) begin
        if (addr_last) begin
          addr <= '0;
          pass <= pass + REPEAT_WIDTH'(1);
        end else begin
          addr <= addr + AWIDTH'(1);
        end
      end
    end
  end

  assign busy     = (state != IDLE);
  // ce stays high through DRAIN so reads already in the ROM keep moving.
  assign rom_ce   = busy;
  assign rom_addr = addr;

  // ---------------- output FIFO ----------------
  assign push = vld_pipe[STAGES];
  assign pop  = strm.data_out_valid && strm.data_out_ready;

  weight_stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({last_pipe[STAGES], rom_q}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign strm.data_out       = fifo_dout[DATA_WIDTH-1:0];
  assign strm.data_out_last  = fifo_dout[DATA_WIDTH];
  assign strm.data_out_valid = !fifo_empty;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full && !pop));
endmodule

// File: tb/tb_weight_rom_stream_ctrl.sv
module tb_weight_rom_stream_ctrl;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH) + 1;
  localparam int RW    = 16;
  localparam int FD    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [RW-1:0] repeat_count = '0;
  logic          busy, done, rom_ce;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q = '0, rom_s1 = '0;
  logic [DW-1:0] rom_mem [0:(1<<AW)-1];

  weight_rom_stream_ctrl_if #(.DATA_WIDTH(DW)) strm();

  weight_rom_stream_ctrl #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AWIDTH(AW), .ROM_LATENCY(2),
    .FIFO_DEPTH(FD), .REPEAT_WIDTH(RW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .repeat_count(repeat_count),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_ce(rom_ce),
    .rom_q(rom_q), .strm(strm)
  );

  always #5 clk = ~clk;

  // ROM model: two registered stages, both frozen when ce is low.
  always @(posedge clk) begin
    if (rom_ce) begin
      rom_s1 <= rom_mem[rom_addr];
      rom_q  <= rom_s1;
    end
  end

  typedef struct {
    logic [DW-1:0] d;
    bit            last;
    bit            fin;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0, passed = 0, xfers = 0;
  int   mode = 0;          // 0 ready=1, 1 toggle, 2 random, 3 ready=0
  bit   zero_req = 1'b0;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // Reference: a run is rep passes over addresses 0..DEPTH-1 in order.
  task automatic expect_run(input int rep);
    exp_t e;
    for (int p = 0; p < rep; p++)
      for (int a = 0; a < DEPTH; a++) begin
        e.d    = rom_mem[a];
        e.last = (a == DEPTH - 1);
        e.fin  = (p == rep - 1) && (a == DEPTH - 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int rep, input bit model);
    repeat_count = RW'(rep);
    start = 1'b1;
    if (model) begin
      if (rep == 0) zero_req = 1'b1;
      else expect_run(rep);
    end
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      cyc(1);
      n++;
    end
    chk(name, n < 3000, 64'(exp_q.size()), 64'(0));
  endtask

  // Ready driver
  initial begin
    strm.data_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       strm.data_out_ready = 1'b1;
        1:       strm.data_out_ready = ~strm.data_out_ready;
        2:       strm.data_out_ready = ($urandom_range(0, 3) != 0);
        default: strm.data_out_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    bit            done_arm, prev_stall;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    exp_t          e;
    done_arm = 1'b0;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_arm   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (done_arm || done)
          chk("done_pulse", done == done_arm, 64'(done), 64'(done_arm));
        done_arm = 1'b0;
        if (zero_req) begin
          done_arm = 1'b1;
          zero_req = 1'b0;
        end
        if (prev_stall)
          chk("hold_stable",
              strm.data_out_valid && strm.data_out == prev_d && strm.data_out_last == prev_l,
              {31'd0, strm.data_out_valid, strm.data_out}, {31'd0, 1'b1, prev_d});
        if (strm.data_out_valid && strm.data_out_ready) begin
          xfers++;
          chk("unexpected_word", exp_q.size() != 0, 64'(strm.data_out), 64'(0));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("word", strm.data_out == e.d && strm.data_out_last == e.last,
                {31'd0, strm.data_out_last, strm.data_out}, {31'd0, e.last, e.d});
            if (e.fin) done_arm = 1'b1;
          end
        end
        prev_stall = strm.data_out_valid && !strm.data_out_ready;
        prev_d     = strm.data_out;
        prev_l     = strm.data_out_last;
      end
    end
  end

  // Stimulus
  initial begin
    int n, base;
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = $urandom;

    // Reset values
    rst = 1'b1;
    cyc(3);
    chk("rst_busy_done", !busy && !done, {62'd0, busy, done}, 64'(0));
    chk("rst_rom", !rom_ce && rom_addr == '0, {59'd0, rom_ce, rom_addr}, 64'(0));
    chk("rst_out", !strm.data_out_valid && !strm.data_out_last && strm.data_out == '0,
        {30'd0, strm.data_out_valid, strm.data_out_last, strm.data_out}, 64'(0));
    rst = 1'b0;
    cyc(2);

    // 1: two passes, full throughput, latency
    mode = 0;
    do_start(2, 1'b1);
    chk("c1_addr_ce", rom_addr == '0 && rom_ce, {59'd0, rom_ce, rom_addr}, 64'h10);
    n = 1;
    while (!strm.data_out_valid && n < 20) begin
      cyc(1);
      n++;
    end
    chk("first_valid_cycle", n == 4, 64'(n), 64'(4));
    wait_idle("t1_idle");

    // 2: ready toggling
    mode = 1;
    cyc(1);
    do_start(1, 1'b1);
    wait_idle("t2_idle");

    // 3: long stall fills the FIFO and stops issuing
    mode = 3;
    cyc(1);
    do_start(1, 1'b1);
    cyc(20);
    chk("stall_issue_stop", rom_addr == AW'(FD), 64'(rom_addr), 64'(FD));
    chk("stall_valid_busy", strm.data_out_valid && busy,
        {62'd0, strm.data_out_valid, busy}, 64'(3));
    mode = 0;
    wait_idle("t3_idle");

    // 4: zero passes
    cyc(2);
    do_start(0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("zero_idle", !rom_ce && !strm.data_out_valid && !busy,
          {61'd0, rom_ce, strm.data_out_valid, busy}, 64'(0));
      cyc(1);
    end

    // 5: reset mid-pass, then restart
    base = xfers;
    do_start(2, 1'b1);
    n = 0;
    while (xfers < base + 4 && n < 100) begin
      cyc(1);
      n++;
    end
    chk("t5_reach_word3", n < 100, 64'(xfers - base), 64'(4));
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    exp_q.delete();
    chk("t5_after_rst", !strm.data_out_valid && !busy && strm.data_out == '0,
        {30'd0, strm.data_out_valid, busy, strm.data_out}, 64'(0));
    cyc(1);
    do_start(1, 1'b1);
    wait_idle("t5_idle");

    // 6: start while busy is ignored
    cyc(2);
    base = xfers;
    do_start(1, 1'b1);
    cyc(3);
    do_start(3, 1'b0);
    wait_idle("t6_idle");
    chk("t6_count", xfers - base == DEPTH, 64'(xfers - base), 64'(DEPTH));

    // 7: randomized runs with random backpressure
    mode = 2;
    for (int r = 0; r < 4; r++) begin
      cyc($urandom_range(1, 4));
      base = xfers;
      n = $urandom_range(1, 3);
      do_start(n, 1'b1);
      wait_idle("t7_idle");
      chk("t7_count", xfers - base == n * DEPTH, 64'(xfers - base), 64'(n * DEPTH));
    end

    cyc(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
